// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the parametrised UART blocks.
//               Holds the receiver state encoding, the parity-mode constants
//               and a helper that returns the total bit count of one frame.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        eIdle   = 3'd0,
        eStart  = 3'd1,
        eData   = 3'd2,
        eParity = 3'd3,
        eStop   = 3'd4
    } uart_state_e;

    // Parity modes accepted by the parity_p parameter.
    localparam int e_parity_none = 0;
    localparam int e_parity_odd  = 1;
    localparam int e_parity_even = 2;

    // Total bits on the line for one frame: start + data + parity + stop.
    function automatic int uart_frame_bits(input int data_bits,
                                           input int parity_mode,
                                           input int stop_bits);
        return 1 + data_bits + ((parity_mode != e_parity_none) ? 1 : 0) + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Loadable down-counter used to time UART bit periods.
//               The counter loads i_load_val when i_load is high, otherwise
//               counts down and holds at zero. o_expire is high while the
//               count is zero; the owner reloads on the expiry cycle to get
//               a period of (load value + 1) cycles.
// Ports       : clk        - clock
//               rst        - synchronous active-high reset (count -> 0)
//               i_load     - load the counter this cycle
//               i_load_val - value to load
//               o_expire   - count has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int clk_per_bit_p = 10416
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_load,
    input  logic [$clog2(clk_per_bit_p)-1:0] i_load_val,
    output logic                             o_expire
);

    localparam int C_W = $clog2(clk_per_bit_p);

    logic [C_W-1:0] r_cnt;
    logic [C_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load) begin
            w_cnt_nxt = i_load_val;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - C_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver with a one-entry ready/valid
//               output register, per-frame parity / framing error flags and
//               an overrun pulse when a finished frame cannot be stored.
//               Optional macro UART_RX_MAJORITY_EN: each bit decision is the
//               majority of three consecutive synchronised samples centred
//               on timer expiry, taken one cycle later than the plain sample.
// Ports       : clk_i        - system clock
//               reset_i      - synchronous active-high reset
//               rx_i         - asynchronous serial line, idles high
//               data_o       - received word, LSB first on the line
//               v_o          - data_o / error flags valid
//               yumi_i       - consumer takes the held word
//               parity_err_o - parity mismatch on the held word
//               frame_err_o  - a stop bit was sampled low on the held word
//               overrun_o    - one-cycle pulse when a frame is dropped
//               busy_o       - receiver is inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int clk_per_bit_p = 10416,
    parameter int data_bits_p   = 8,
    parameter int parity_p      = 0,
    parameter int stop_bits_p   = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   rx_i,
    output logic [data_bits_p-1:0] data_o,
    output logic                   v_o,
    input  logic                   yumi_i,
    output logic                   parity_err_o,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic                   busy_o
);

    localparam int C_TMR_W = $clog2(clk_per_bit_p);
    localparam int C_CNT_W = $clog2(uart_frame_bits(data_bits_p, parity_p, stop_bits_p));

    localparam logic [C_TMR_W-1:0] C_HALF_BIT   = C_TMR_W'(clk_per_bit_p / 2 - 1);
    localparam logic [C_TMR_W-1:0] C_FULL_BIT   = C_TMR_W'(clk_per_bit_p - 1);
    localparam logic [C_CNT_W-1:0] C_LAST_DATA  = C_CNT_W'(data_bits_p - 1);
    localparam logic [C_CNT_W-1:0] C_LAST_STOP  = C_CNT_W'(stop_bits_p - 1);
    localparam logic               C_HAS_PARITY = (parity_p != e_parity_none);
    localparam logic               C_ODD        = (parity_p == e_parity_odd);

    // ------------------------------------------------------------------------
    // Input synchroniser plus one extra stage for falling-edge detection.
    // ------------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_fall;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // A held-low line (break) never re-triggers: rx_s must go high first.
    assign w_fall = r_rx_prev & ~r_rx_sync;

    // ------------------------------------------------------------------------
    // Bit timer
    // ------------------------------------------------------------------------
    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic                 w_tmr_load;
    logic [C_TMR_W-1:0]   w_tmr_val;
    logic                 w_tmr_expire;

    // Idle loads the half-bit delay on an edge; every in-frame expiry
    // reloads a full bit so sample points stay one bit apart.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = C_FULL_BIT;
        if (r_state == eIdle) begin
            if (w_fall) begin
                w_tmr_load = 1'b1;
                w_tmr_val  = C_HALF_BIT;
            end
        end else if (w_tmr_expire) begin
            w_tmr_load = 1'b1;
        end
    end

    uart_bit_timer #(
        .clk_per_bit_p (clk_per_bit_p)
    ) u_bit_timer (
        .clk        (clk_i),
        .rst        (reset_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_expire   (w_tmr_expire)
    );

    // ------------------------------------------------------------------------
    // Sample event / sampled bit
    // ------------------------------------------------------------------------
    logic w_smp_evt;
    logic w_smp_bit;

`ifdef UART_RX_MAJORITY_EN
    // At expiry r_rx_prev holds the value seen at timer==1 and r_rx_sync the
    // value at timer==0; the third vote is rx_s on the following cycle.
    logic r_maj_a;
    logic r_maj_b;
    logic r_maj_pend;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_maj_a    <= 1'b1;
            r_maj_b    <= 1'b1;
            r_maj_pend <= 1'b0;
        end else begin
            r_maj_pend <= w_tmr_expire & (r_state != eIdle);
            if (w_tmr_expire) begin
                r_maj_a <= r_rx_prev;
                r_maj_b <= r_rx_sync;
            end
        end
    end

    assign w_smp_evt = r_maj_pend;
    assign w_smp_bit = (r_maj_a & r_maj_b) | (r_maj_a & r_rx_sync) | (r_maj_b & r_rx_sync);
`else
    assign w_smp_evt = w_tmr_expire & (r_state != eIdle);
    assign w_smp_bit = r_rx_sync;
`endif

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    logic [data_bits_p-1:0] r_shift;
    logic [data_bits_p-1:0] w_shift_nxt;
    logic [C_CNT_W-1:0]     r_cnt;
    logic [C_CNT_W-1:0]     w_cnt_nxt;
    logic                   r_perr;
    logic                   w_perr_nxt;
    logic                   r_ferr;
    logic                   w_ferr_nxt;
    logic                   w_frame_done;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= eIdle;
            r_shift <= '0;
            r_cnt   <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_perr  <= w_perr_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_perr_nxt   = r_perr;
        w_ferr_nxt   = r_ferr;
        w_frame_done = 1'b0;
        case (r_state)
            eIdle: begin
                if (w_fall) begin
                    w_state_nxt = eStart;
                end
            end
            eStart: begin
                if (w_smp_evt) begin
                    if (!w_smp_bit) begin
                        w_state_nxt = eData;
                        w_cnt_nxt   = '0;
                        w_perr_nxt  = 1'b0;
                        w_ferr_nxt  = 1'b0;
                    end else begin
                        // Line was high again at mid-start: a glitch.
                        w_state_nxt = eIdle;
                    end
                end
            end
            eData: begin
                if (w_smp_evt) begin
                    w_shift_nxt = {w_smp_bit, r_shift[data_bits_p-1:1]};
                    if (r_cnt == C_LAST_DATA) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = C_HAS_PARITY ? eParity : eStop;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_W'(1);
                    end
                end
            end
            eParity: begin
                if (w_smp_evt) begin
                    // Odd mode expects XOR(data, bit) = 1, even expects 0.
                    w_perr_nxt  = (^r_shift) ^ w_smp_bit ^ C_ODD;
                    w_state_nxt = eStop;
                end
            end
            eStop: begin
                if (w_smp_evt) begin
                    w_ferr_nxt = r_ferr | ~w_smp_bit;
                    if (r_cnt == C_LAST_STOP) begin
                        // Re-arm at mid-stop for half-bit resync tolerance.
                        w_state_nxt  = eIdle;
                        w_frame_done = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = eIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // One-entry output register
    // ------------------------------------------------------------------------
    logic [data_bits_p-1:0] r_data;
    logic                   r_v;
    logic                   r_out_perr;
    logic                   r_out_ferr;
    logic                   r_overrun;
    logic                   w_accept;

    assign w_accept = w_frame_done & (~r_v | yumi_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_data     <= '0;
            r_v        <= 1'b0;
            r_out_perr <= 1'b0;
            r_out_ferr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= w_frame_done & ~w_accept;
            if (w_accept) begin
                r_data     <= r_shift;
                r_out_perr <= r_perr;
                r_out_ferr <= w_ferr_nxt;
                r_v        <= 1'b1;
            end else if (yumi_i) begin
                r_v <= 1'b0;
            end
        end
    end

    assign data_o       = r_data;
    assign v_o          = r_v;
    assign parity_err_o = r_out_perr;
    assign frame_err_o  = r_out_ferr;
    assign overrun_o    = r_overrun;
    assign busy_o       = (r_state != eIdle);

endmodule
`default_nettype wire
